juego_led_juez: RTL
===================

# juego_led_juez

Judge stage of the LED reaction game; it sits directly upstream of the hit counter. It runs a one-hot LED chaser, debounces the player's push button, and decides whether each press landed on the target LED. For every accepted press it emits a one-cycle `Modificar` strobe qualified by `Modo`: 1 means hit (increment), 0 means miss (decrement). Once the counter reports `GanadorTT`, the block freezes play into a winner display until reset.

## Interface
- `N_LED`, 8, number of LEDs in the chaser (≥2)
- `OBJETIVO`, 3, target LED index (0..N_LED-1)
- `DEB_CYC`, 20, consecutive stable cycles required to accept a button level change (≥1)
- `PASO_INI`, 250, cycles per chaser step after reset
- `PASO_DEC`, 25, step-period reduction applied per hit
- `PASO_MIN`, 100, floor for the step period
- `PAUSA_CYC`, 500, cycles the chaser stays frozen after a judged press
- `BLINK_CYC`, 250, half-period of the winner blink

- `clock1k` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `boton` in 1: raw asynchronous push button, active-high, may bounce
- `GanadorTT` in 1: winner flag returned by the counter stage
- `leds` out N_LED: LED drive
- `Modo` out 1: direction qualifier, 1 = hit, 0 = miss
- `Modificar` out 1: one-cycle strobe per judged press

## Operation
- **Input path:** `boton` passes through a 2-FF synchronizer, then the debouncer.
  - The debounced level `deb` changes only after the synchronized value differs from it for DEB_CYC consecutive cycles.
  - Any agreeing cycle clears the debounce count.
- **Press event:** a rising edge of `deb`. Falling edges are ignored.
- **Chaser:** `pos` is an index 0..N_LED-1 and `stepcnt` is a cycle counter.
  - When `stepcnt` reaches `periodo`-1, it clears and `pos` advances by 1.
  - After N_LED-1, `pos` wraps to 0.
  - `leds` = one-hot of `pos`.
- **States:**
  - CORRE: the chaser runs. A press event compares the `pos` value registered in that same cycle against OBJETIVO.
    - Set `Modo`=(pos==OBJETIVO) and pulse `Modificar` for exactly one cycle.
    - Go to PAUSA with `leds` frozen at the judged position.
    - On a hit, `periodo` becomes max(`periodo`-PASO_DEC, PASO_MIN); on a miss it is unchanged.
  - PAUSA: `leds` are frozen. A counter runs PAUSA_CYC cycles; after that, go to CORRE with `pos`=0 and `stepcnt`=0.
    - Press events in PAUSA are discarded, not queued.
  - GANO: entered from CORRE or PAUSA in the cycle after `GanadorTT` is sampled 1.
    - `leds` alternate all-ones and all-zeros every BLINK_CYC cycles, starting with all-ones.
    - No `Modificar` is issued. The only exit is `reset`.
- **Modo hold:** `Modo` keeps its last value between strobes, so it is stable around every strobe edge.
- **Period arithmetic:** `periodo` is unsigned and sized for PASO_INI. The subtraction saturates at PASO_MIN and never underflows.

## Timing
- **Reset values** (every output and register):
  - `leds`=one-hot bit 0, `Modo`=0, `Modificar`=0
  - state CORRE, `pos`=0, `stepcnt`=0, `periodo`=PASO_INI
  - `deb`=0, synchronizer=0
- **Press latency:** for a clean `boton` rise sampled at edge k, `Modificar` is high during cycle k+DEB_CYC+3 only.
- **Strobe timing:** `Modo` is updated on the same edge that raises `Modificar`. The downstream counter samples on the falling edge of that cycle, so both must be settled by mid-cycle.
- **Press on a step boundary:** the judgement uses the pre-advance `pos`. The freeze shows that same LED.
- **GanadorTT with a press in the same cycle:** the strobe still issues, then the block enters GANO.
- **Button held through reset release:** counts as a press after DEB_CYC+3 cycles.
- **Reset mid-operation:** reset asserted in any state returns everything to reset values on the next edge. A strobe in flight is cancelled, so `Modificar` is 0 on that edge.
- **Strobe spacing:** consecutive strobes are never closer than PAUSA_CYC+1 cycles.

## Test plan
All scenarios use N_LED=8, OBJETIVO=3, DEB_CYC=4, PASO_INI=10, PASO_DEC=2, PASO_MIN=4, PAUSA_CYC=6, BLINK_CYC=5.

- **Reset / chaser:** hold reset 3 cycles, then release. `leds`=8'h01, `Modo`=0, `Modificar`=0. `leds` becomes 8'h02 after 10 cycles, and wraps from 8'h80 to 8'h01 after 80 cycles total.
- **Bounce rejection:** toggle `boton` 1/0 every 2 cycles for 20 cycles, then hold 1.
  - No strobe during bouncing.
  - Exactly one strobe 7 cycles after the steady hold begins.
- **Hit and speed-up:** press cleanly so it is judged at `pos`=3.
  - `Modo`=1 with a 1-cycle `Modificar`, and `leds`=8'h08 frozen for 6 cycles.
  - Chaser restarts at 8'h01 and steps every 8 cycles.
  - Four further hits leave the step period at 4 (saturated).
- **Miss and pause discard:** press judged at `pos`=5, then press again during PAUSA.
  - `Modo`=0, `leds`=8'h20 frozen, one strobe only.
  - The second press produces nothing.
- **Winner:** assert `GanadorTT` while in CORRE.
  - Next cycle `leds`=8'hFF, then 8'h00 after 5 cycles, alternating.
  - Presses produce no strobe; reset returns `leds` to 8'h01.
- **Reset mid-strobe:** assert reset on the edge where `Modificar` would rise. `Modificar` stays 0 and all registers hold reset values.

Source files
------------

// File: rtl/juego_led_juez_if.sv
// rtl/juego_led_juez_if.sv - button, winner flag and LED/strobe bundle of the judge stage
interface juego_led_juez_if #(
  parameter int N_LED = 8
);
  logic             boton;
  logic             GanadorTT;
  logic [N_LED-1:0] leds;
  logic             Modo;
  logic             Modificar;

  modport master (
    output boton,
    output GanadorTT,
    input  leds,
    input  Modo,
    input  Modificar
  );

  modport slave (
    input  boton,
    input  GanadorTT,
    output leds,
    output Modo,
    output Modificar
  );
endinterface

// File: rtl/juego_led_juez.sv
// rtl/juego_led_juez.sv - LED chaser, button debouncer and hit/miss judge for the reaction game
module juego_led_juez #(
  parameter int N_LED     = 8,
  parameter int OBJETIVO  = 3,
  parameter int DEB_CYC   = 20,
  parameter int PASO_INI  = 250,
  parameter int PASO_DEC  = 25,
  parameter int PASO_MIN  = 100,
  parameter int PAUSA_CYC = 500,
  parameter int BLINK_CYC = 250
) (
  input logic           clock1k,
  input logic           reset,
  juego_led_juez_if.slave bus
);

  localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int TW = $clog2(PASO_INI + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int QW = $clog2(PAUSA_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);

  localparam logic [PW-1:0] POS_LAST   = PW'(N_LED - 1);
  localparam logic [PW-1:0] POS_OBJ    = PW'(OBJETIVO);
  localparam logic [TW-1:0] PER_INI    = TW'(PASO_INI);
  localparam logic [TW-1:0] PER_DEC    = TW'(PASO_DEC);
  localparam logic [TW-1:0] PER_MIN    = TW'(PASO_MIN);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
  localparam logic [QW-1:0] PAUSA_LAST = QW'(PAUSA_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {CORRE, PAUSA, GANO} estado_t;

  logic          sync1, sync2, deb, deb_q, pulso;
  logic [DW-1:0] deb_cnt;

  estado_t       estado, estado_n;
  logic [PW-1:0] pos, pos_n;
  logic [TW-1:0] stepcnt, stepcnt_n;
  logic [TW-1:0] periodo, periodo_n;
  logic [QW-1:0] pcnt, pcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          blink, blink_n;
  logic          modo, modo_n;
  logic          modificar, modificar_n;
  logic [N_LED-1:0] leds_r;

  // pulso is registered so the judge sees the press one cycle after deb rises
  always_ff @(posedge clock1k) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
      pulso   <= 1'b0;
    end else begin
      sync1 <= bus.boton;
      sync2 <= sync1;
      deb_q <= deb;
      pulso <= deb & ~deb_q;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clock1k) begin
    if (reset) begin
      estado    <= CORRE;
      pos       <= '0;
      stepcnt   <= '0;
      periodo   <= PER_INI;
      pcnt      <= '0;
      bcnt      <= '0;
      blink     <= 1'b1;
      modo      <= 1'b0;
      modificar <= 1'b0;
    end else begin
      estado    <= estado_n;
      pos       <= pos_n;
      stepcnt   <= stepcnt_n;
      periodo   <= periodo_n;
      pcnt      <= pcnt_n;
      bcnt      <= bcnt_n;
      blink     <= blink_n;
      modo      <= modo_n;
      modificar <= modificar_n;
    end
  end

  always_comb begin
    estado_n    = estado;
    pos_n       = pos;
    stepcnt_n   = stepcnt;
    periodo_n   = periodo;
    pcnt_n      = pcnt;
    bcnt_n      = bcnt;
    blink_n     = blink;
    modo_n      = modo;
    modificar_n = 1'b0;
    case (estado)
      CORRE: begin
        // a press wins over a step boundary, so the frozen LED is the judged one
        if (pulso) begin
          modificar_n = 1'b1;
          modo_n      = (pos == POS_OBJ);
          pcnt_n      = '0;
          estado_n    = PAUSA;
          if (pos == POS_OBJ) begin
            if (periodo >= PER_MIN && (periodo - PER_MIN) >= PER_DEC)
              periodo_n = periodo - PER_DEC;
            else
              periodo_n = PER_MIN;
          end
        end else if (stepcnt == periodo - TW'(1)) begin
          stepcnt_n = '0;
          pos_n     = (pos == POS_LAST) ? '0 : pos + PW'(1);
        end else begin
          stepcnt_n = stepcnt + TW'(1);
        end
      end
      PAUSA: begin
        if (pcnt == PAUSA_LAST) begin
          estado_n  = CORRE;
          pos_n     = '0;
          stepcnt_n = '0;
        end else begin
          pcnt_n = pcnt + QW'(1);
        end
      end
      GANO: begin
        if (bcnt == BLINK_LAST) begin
          bcnt_n  = '0;
          blink_n = ~blink;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      default: estado_n = CORRE;
    endcase
    // winner overrides the next state but leaves a same-cycle strobe intact
    if (bus.GanadorTT && estado != GANO) begin
      estado_n = GANO;
      bcnt_n   = '0;
      blink_n  = 1'b1;
    end
  end

  always_comb begin
    leds_r = '0;
    if (estado == GANO)
      leds_r = {N_LED{blink}};
    else
      leds_r[pos] = 1'b1;
  end

  assign bus.leds      = leds_r;
  assign bus.Modo      = modo;
  assign bus.Modificar = modificar;

endmodule
